// File: rtl/point_stream_checker.sv
// point_stream_checker
//   Receive-side checker for the two point streams from the point generator.
//   Channel A is expected to count up (+1 on x and y, modulo 256) and channel B
//   to count down (-1 on x and y, modulo 256). Each channel locks onto the
//   running sequence, tracks the expected next point, pulses err on a mismatch
//   while tracking and keeps a saturating error count.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   clr        synchronous clear: counters to 0, both channels back to HUNT
//   point_i_A  channel A sample {x[7:0], y[7:0]}
//   valid_i_A  point_i_A valid this cycle
//   point_i_B  channel B sample {x[7:0], y[7:0]}
//   valid_i_B  point_i_B valid this cycle
//   locked_A/B channel is in TRACK (registered)
//   err_A/B    one-cycle pulse, the cycle after a mismatching sample in TRACK
//   err_cnt_A/B saturating count of err pulses

module point_stream_checker_ch #(
  parameter int CNT_W     = 16,
  parameter int LOCK_N    = 4,
  parameter int MISS_N    = 3,
  parameter bit STEP_DOWN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [15:0]      pt_p0,
  input  logic             vld_p0,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LOCK  = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam logic [3:0]       LOCK_T  = 4'(LOCK_N);
  localparam logic [3:0]       MISS_T  = 4'(MISS_N);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // x and y advance independently and wrap at 8 bits.
  function automatic logic [15:0] step_pt(input logic [15:0] p);
    logic [7:0] d;
    d = STEP_DOWN ? 8'hff : 8'h01;
    return {p[15:8] + d, p[7:0] + d};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  state_t           state_p1, state_nx;
  logic [15:0]      exp_p1, exp_nx;
  logic [3:0]       good_p1, good_nx;
  logic [3:0]       miss_p1, miss_nx;
  logic             err_p1, err_nx;
  logic             locked_p1;
  logic [CNT_W-1:0] cnt_p1, cnt_nx;
  logic             match_p0;

  assign match_p0 = (pt_p0 == exp_p1);

  // stage p0 -> p1: sample compared against the tracked expectation
  always_comb begin
    state_nx = state_p1;
    exp_nx   = exp_p1;
    good_nx  = good_p1;
    miss_nx  = miss_p1;
    cnt_nx   = cnt_p1;
    err_nx   = 1'b0;
    if (vld_p0) begin
      unique case (state_p1)
        HUNT: begin
          exp_nx   = step_pt(pt_p0);
          good_nx  = 4'd1;
          miss_nx  = 4'd0;
          state_nx = (LOCK_N == 1) ? TRACK : LOCK;
        end
        LOCK: begin
          if (match_p0) begin
            exp_nx  = step_pt(exp_p1);
            good_nx = good_p1 + 4'd1;
            if (good_p1 + 4'd1 == LOCK_T) begin
              state_nx = TRACK;
              miss_nx  = 4'd0;
            end
          end else begin
            // Re-seed from the new sample; no error while still acquiring.
            exp_nx  = step_pt(pt_p0);
            good_nx = 4'd1;
          end
        end
        TRACK: begin
          // Expectation free-runs so a single glitched sample does not
          // desynchronise the following good ones.
          exp_nx = step_pt(exp_p1);
          if (match_p0) begin
            miss_nx = 4'd0;
          end else begin
            err_nx  = 1'b1;
            cnt_nx  = sat_inc(cnt_p1);
            miss_nx = miss_p1 + 4'd1;
            if (miss_p1 + 4'd1 == MISS_T) state_nx = HUNT;
          end
        end
        default: state_nx = HUNT;
      endcase
    end
    if (clr) begin
      state_nx = HUNT;
      exp_nx   = exp_p1;
      good_nx  = 4'd0;
      miss_nx  = 4'd0;
      cnt_nx   = '0;
      err_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1  <= HUNT;
      exp_p1    <= 16'h0000;
      good_p1   <= 4'd0;
      miss_p1   <= 4'd0;
      err_p1    <= 1'b0;
      locked_p1 <= 1'b0;
      cnt_p1    <= '0;
    end else begin
      state_p1  <= state_nx;
      exp_p1    <= exp_nx;
      good_p1   <= good_nx;
      miss_p1   <= miss_nx;
      err_p1    <= err_nx;
      locked_p1 <= (state_nx == TRACK);
      cnt_p1    <= cnt_nx;
    end
  end

  assign locked  = locked_p1;
  assign err     = err_p1;
  assign err_cnt = cnt_p1;

endmodule

module point_stream_checker #(
  parameter int CNT_W  = 16,
  parameter int LOCK_N = 4,
  parameter int MISS_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [15:0]      point_i_A,
  input  logic             valid_i_A,
  input  logic [15:0]      point_i_B,
  input  logic             valid_i_B,
  output logic             locked_A,
  output logic             locked_B,
  output logic             err_A,
  output logic             err_B,
  output logic [CNT_W-1:0] err_cnt_A,
  output logic [CNT_W-1:0] err_cnt_B
);

  point_stream_checker_ch #(
    .CNT_W(CNT_W), .LOCK_N(LOCK_N), .MISS_N(MISS_N), .STEP_DOWN(1'b0)
  ) u_ch_a (
    .clk(clk), .rst(rst), .clr(clr),
    .pt_p0(point_i_A), .vld_p0(valid_i_A),
    .locked(locked_A), .err(err_A), .err_cnt(err_cnt_A)
  );

  point_stream_checker_ch #(
    .CNT_W(CNT_W), .LOCK_N(LOCK_N), .MISS_N(MISS_N), .STEP_DOWN(1'b1)
  ) u_ch_b (
    .clk(clk), .rst(rst), .clr(clr),
    .pt_p0(point_i_B), .vld_p0(valid_i_B),
    .locked(locked_B), .err(err_B), .err_cnt(err_cnt_B)
  );

endmodule

// File: tb/tb_point_stream_checker.sv
// tb_point_stream_checker
//   Drives two instances of point_stream_checker: a default build
//   (CNT_W=16, LOCK_N=4, MISS_N=3) and a narrow build (CNT_W=4, LOCK_N=4,
//   MISS_N=15) for counter saturation. Outputs are compared every cycle
//   against a per-channel reference model written from the channel rules.

module tb_point_stream_checker;

  localparam int HUNT = 0, LOCK = 1, TRACK = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic [15:0] pa = 16'h0, pb = 16'h0, ps = 16'h0;
  logic        va = 1'b0, vb = 1'b0, vs = 1'b0;

  logic        locked_A, locked_B, err_A, err_B;
  logic [15:0] err_cnt_A, err_cnt_B;
  logic        s_locked_A, s_locked_B, s_err_A, s_err_B;
  logic [3:0]  s_cnt_A, s_cnt_B;

  point_stream_checker dut (
    .clk(clk), .rst(rst), .clr(clr),
    .point_i_A(pa), .valid_i_A(va),
    .point_i_B(pb), .valid_i_B(vb),
    .locked_A(locked_A), .locked_B(locked_B),
    .err_A(err_A), .err_B(err_B),
    .err_cnt_A(err_cnt_A), .err_cnt_B(err_cnt_B)
  );

  point_stream_checker #(.CNT_W(4), .LOCK_N(4), .MISS_N(15)) dut_s (
    .clk(clk), .rst(rst), .clr(clr),
    .point_i_A(ps), .valid_i_A(vs),
    .point_i_B(16'h0000), .valid_i_B(1'b0),
    .locked_A(s_locked_A), .locked_B(s_locked_B),
    .err_A(s_err_A), .err_B(s_err_B),
    .err_cnt_A(s_cnt_A), .err_cnt_B(s_cnt_B)
  );

  always #5 clk = ~clk;

  // Reference model: channel 0 = A, 1 = B (default build); 2 = A, 3 = B (narrow build).
  int m_st[4], m_ex[4], m_ey[4], m_good[4], m_miss[4], m_cnt[4];
  bit m_err[4];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_st[c] = HUNT; m_ex[c] = 0; m_ey[c] = 0;
      m_good[c] = 0; m_miss[c] = 0; m_cnt[c] = 0; m_err[c] = 1'b0;
    end
  endtask

  task automatic model_ch(input int ch, input bit v, input int x, input int y, input bit c);
    int s, mn, cmax;
    bit hit;
    s    = (ch % 2 == 1) ? -1 : 1;
    mn   = (ch < 2) ? 3 : 15;
    cmax = (ch < 2) ? 65535 : 15;
    m_err[ch] = 1'b0;
    if (c) begin
      m_st[ch] = HUNT; m_good[ch] = 0; m_miss[ch] = 0; m_cnt[ch] = 0;
      return;
    end
    if (!v) return;
    hit = (x == m_ex[ch]) && (y == m_ey[ch]);
    case (m_st[ch])
      HUNT: begin
        m_ex[ch] = (x + s) & 255; m_ey[ch] = (y + s) & 255;
        m_good[ch] = 1; m_miss[ch] = 0; m_st[ch] = LOCK;
      end
      LOCK: begin
        if (hit) begin
          m_ex[ch] = (m_ex[ch] + s) & 255; m_ey[ch] = (m_ey[ch] + s) & 255;
          m_good[ch]++;
          if (m_good[ch] == 4) begin m_st[ch] = TRACK; m_miss[ch] = 0; end
        end else begin
          m_ex[ch] = (x + s) & 255; m_ey[ch] = (y + s) & 255; m_good[ch] = 1;
        end
      end
      default: begin
        m_ex[ch] = (m_ex[ch] + s) & 255; m_ey[ch] = (m_ey[ch] + s) & 255;
        if (hit) m_miss[ch] = 0;
        else begin
          m_err[ch] = 1'b1;
          if (m_cnt[ch] < cmax) m_cnt[ch]++;
          m_miss[ch]++;
          if (m_miss[ch] == mn) m_st[ch] = HUNT;
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    check("locked_A",  int'(locked_A),   int'(m_st[0] == TRACK));
    check("err_A",     int'(err_A),      int'(m_err[0]));
    check("err_cnt_A", int'(err_cnt_A),  m_cnt[0]);
    check("locked_B",  int'(locked_B),   int'(m_st[1] == TRACK));
    check("err_B",     int'(err_B),      int'(m_err[1]));
    check("err_cnt_B", int'(err_cnt_B),  m_cnt[1]);
    check("s_locked_A", int'(s_locked_A), int'(m_st[2] == TRACK));
    check("s_err_A",    int'(s_err_A),    int'(m_err[2]));
    check("s_cnt_A",    int'(s_cnt_A),    m_cnt[2]);
    check("s_locked_B", int'(s_locked_B), int'(m_st[3] == TRACK));
    check("s_err_B",    int'(s_err_B),    int'(m_err[3]));
    check("s_cnt_B",    int'(s_cnt_B),    m_cnt[3]);
  endtask

  // Inputs are set at a falling edge; the model steps with them, the rising
  // edge captures them, and outputs are compared at the next falling edge.
  task automatic tick();
    model_ch(0, va, int'(pa[15:8]), int'(pa[7:0]), clr);
    model_ch(1, vb, int'(pb[15:8]), int'(pb[7:0]), clr);
    model_ch(2, vs, int'(ps[15:8]), int'(ps[7:0]), clr);
    model_ch(3, 1'b0, 0, 0, clr);
    @(negedge clk);
    check_outputs();
    va = 1'b0; vb = 1'b0; vs = 1'b0; clr = 1'b0;
  endtask

  task automatic send_a(input int x, input int y);
    va = 1'b1; pa = {8'(x), 8'(y)}; tick();
  endtask

  task automatic send_b(input int x, input int y);
    vb = 1'b1; pb = {8'(x), 8'(y)}; tick();
  endtask

  task automatic do_clr();
    clr = 1'b1; tick();
  endtask

  // Reset asserted and checked between clock edges, released before the next edge.
  task automatic async_rst();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_locked_A", int'(locked_A), 0);
    check("arst_err_cnt_A", int'(err_cnt_A), 0);
    check_outputs();
    #1 rst = 1'b0;
  endtask

  initial begin
    int k, nmis;
    int ax, ay, bx, by, sx, sy;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    check("rst_locked_A", int'(locked_A), 0);
    rst = 1'b0;

    // 1: lock across a valid gap
    send_a(0, 0); send_a(1, 1); tick(); send_a(2, 2);
    check("t1_not_yet", int'(locked_A), 0);
    send_a(3, 3);
    check("t1_locked", int'(locked_A), 1);
    send_a(4, 4); send_a(5, 5);
    check("t1_cnt", int'(err_cnt_A), 0);

    // 2: both channels across the 8-bit wrap
    do_clr();
    for (int i = 0; i < 11; i++) begin
      va = 1'b1; pa = {8'(8'hf8 + i), 8'(8'hf8 + i)};
      vb = 1'b1; pb = {8'(8'h07 - i), 8'(8'h07 - i)};
      tick();
      if (i >= 3) begin
        check("t2_locked_A", int'(locked_A), 1);
        check("t2_locked_B", int'(locked_B), 1);
        check("t2_err_A", int'(err_A), 0);
        check("t2_err_B", int'(err_B), 0);
      end
    end

    // 3: single glitch tolerated
    do_clr();
    for (int i = 0; i < 5; i++) send_a(8'h10 + i, 8'h10 + i);
    send_a(8'h15, 8'h99);
    check("t3_err", int'(err_A), 1);
    check("t3_cnt", int'(err_cnt_A), 1);
    check("t3_locked", int'(locked_A), 1);
    send_a(8'h16, 8'h16);
    check("t3_err_after", int'(err_A), 0);
    check("t3_locked_after", int'(locked_A), 1);
    check("t3_cnt_after", int'(err_cnt_A), 1);

    // 4: three misses drop lock on B, then re-acquire
    do_clr();
    for (int i = 0; i < 4; i++) send_b(8'h50 - i, 8'h50 - i);
    check("t4_locked", int'(locked_B), 1);
    for (int i = 0; i < 3; i++) begin
      send_b(8'h11, 8'h22);
      check("t4_err", int'(err_B), 1);
      check("t4_cnt", int'(err_cnt_B), i + 1);
    end
    check("t4_unlocked", int'(locked_B), 0);
    send_b(8'h40, 8'h40);
    check("t4_relock_wait", int'(locked_B), 0);
    for (int i = 1; i < 4; i++) send_b(8'h40 - i, 8'h40 - i);
    check("t4_relocked", int'(locked_B), 1);

    // 5: 4-bit counter saturates
    do_clr();
    k = 0; nmis = 0;
    for (int it = 0; it < 300 && nmis < 20; it++) begin
      vs = 1'b1;
      if (m_st[2] == TRACK) begin ps = {8'(k), 8'(k ^ 8'h55)}; nmis++; end
      else ps = {8'(k), 8'(k)};
      k = (k + 1) & 255;
      tick();
    end
    check("t5_mismatches", nmis, 20);
    check("t5_sat", int'(s_cnt_A), 15);

    // 6: clr beats a sample; async reset between edges
    do_clr();
    for (int i = 0; i < 4; i++) send_a(8'h30 + i, 8'h30 + i);
    send_a(8'h00, 8'h00);
    check("t6_pre_cnt", int'(err_cnt_A), 1);
    va = 1'b1; pa = {8'h35, 8'h35}; clr = 1'b1; tick();
    check("t6_locked", int'(locked_A), 0);
    check("t6_cnt", int'(err_cnt_A), 0);
    for (int i = 0; i < 4; i++) send_a(8'h60 + i, 8'h60 + i);
    check("t6_pre_rst", int'(locked_A), 1);
    async_rst();
    tick();

    // Random streams with glitches, gaps, clears and one mid-stream reset
    ax = $urandom_range(255); ay = $urandom_range(255);
    bx = $urandom_range(255); by = $urandom_range(255);
    sx = $urandom_range(255); sy = $urandom_range(255);
    for (int it = 0; it < 2000; it++) begin
      if ($urandom_range(3) != 0) begin
        va = 1'b1;
        pa = ($urandom_range(15) == 0) ? 16'($urandom) : {8'(ax), 8'(ay)};
        ax = (ax + 1) & 255; ay = (ay + 1) & 255;
      end
      if ($urandom_range(3) != 0) begin
        vb = 1'b1;
        pb = ($urandom_range(15) == 0) ? 16'($urandom) : {8'(bx), 8'(by)};
        bx = (bx - 1) & 255; by = (by - 1) & 255;
      end
      if ($urandom_range(3) != 0) begin
        vs = 1'b1;
        ps = ($urandom_range(5) == 0) ? 16'($urandom) : {8'(sx), 8'(sy)};
        sx = (sx + 1) & 255; sy = (sy + 1) & 255;
      end
      clr = ($urandom_range(199) == 0);
      tick();
      if (it == 1000) begin
        async_rst();
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
